ldl_round_pri_age: RTL and testbench
====================================

Name: ldl_round_pri_age

Overview:
- Round-robin arbiter with per-requester class of service (COS); next generation of the team's priority round-robin arbiter.
- Adds anti-starvation aging: a low-class requester that keeps losing is promoted to top class.
- Adds packet lock: a grant is held across multi-beat transfers until a `last` beat completes.
- Sits in front of shared buses and egress ports where multi-beat packets must not be interleaved.

Parameters:
- BIN_WIDTH, 3, width of the binary grant index.
- COS_WIDTH, 2, width of the per-requester class; 0 is lowest, all-ones is highest.
- REQ_WIDTH, 1<<BIN_WIDTH, number of requesters.
- AGE_WIDTH, 4, width of the per-requester aging counter.
- AGE_LIMIT, 15, number of lost packets after which a requester is promoted; must be between 1 and 2^AGE_WIDTH-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low (0 is reset).
- req  input  REQ_WIDTH  request vector.
- cos  input  REQ_WIDTH x COS_WIDTH  packed per-requester class.
- last  input  1  final beat of the current packet; sampled only on a handshake.
- ready  input  1  downstream accepts the current beat.
- hot  output  REQ_WIDTH  one-hot grant.
- bin  output  BIN_WIDTH  binary index of the granted requester.
- valid  output  1  grant is valid.
- locked  output  1  arbiter is holding a grant mid-packet.

Behaviour:
- Handshake: hs = valid & ready.
- Packet end: pe = hs & last.
- Reset state (rst_n=0, asynchronous):
  - ptr = REQ_WIDTH-1, so requester 0 wins first.
  - state = ARB.
  - All age counters = 0.
  - Outputs follow combinationally: with req=0, hot=0, bin=0, valid=0, locked=0.
- State machine, two states:
  - ARB: grant is computed combinationally (zero latency). On hs with last=0, go to LOCK and set lock_idx=bin. On pe, stay in ARB and set ptr=bin.
  - LOCK: hot=1<<lock_idx, bin=lock_idx, valid=req[lock_idx]. req and cos of all others are ignored. On pe, go to ARB and set ptr=lock_idx. On hs with last=0, stay in LOCK.
  - If req[lock_idx] drops in LOCK: valid=0, hot/bin still show lock_idx, and the state stays LOCK. The requester owns the path until its `last` beat.
  - locked = (state==LOCK).
- Effective class:
  - eff[i] = all-ones if age[i] >= AGE_LIMIT, else cos[i].
  - max_eff = maximum eff[i] over i with req[i]=1; 0 if there are no requests.
  - Candidate set: req[i] & (eff[i]==max_eff).
- Round-robin pick:
  - Search candidates starting at index ptr+1 (mod REQ_WIDTH) and wrapping. The first hit wins.
  - No candidates: valid=0, hot=0, bin=0.
  - ptr advances only at packet end. It never advances on a non-last beat or when there is no handshake.
- Aging, updated only on pe:
  - For each i != granted index with req[i]=1: age[i] = min(age[i]+1, 2^AGE_WIDTH-1), i.e. saturating.
  - The granted requester's age is cleared to 0.
  - Any i with req[i]=0 in any cycle has its age cleared to 0.
  - Ages are unchanged when there is no pe.
- Boundary conditions:
  - Several aged requesters tie at top class: normal round robin among them.
  - A requester already at cos all-ones sees no change from aging.
  - A single requester with back-to-back packets keeps winning, and ptr equals its index.
  - ptr wraps from REQ_WIDTH-1 to 0.
  - req changing mid-cycle in ARB changes the grant combinationally. Requesters must hold req until hs.
  - Asynchronous reset mid-packet: immediately returns to ARB, ages cleared, ptr = REQ_WIDTH-1.
  - A single-beat packet (hs with last=1 in ARB) never enters LOCK.

Decomposition:
- Shared package ldl_round_pkg:
  - state enum typedef {ARB, LOCK}.
  - Typedefs for the req vector, the cos array and the age array, parameterised through the module.
- Sub-module ldl_rr_pick:
  - Combinational rotating-priority search.
  - Inputs: cand[REQ_WIDTH], ptr[BIN_WIDTH].
  - Outputs: hot, bin, any.
  - Reused by future arbiters.
- Top module holds: COS/aging compare, age counters, ptr, and the lock FSM.

Test Plan:
- Reset release, req=8'b0000_0101, all cos=0, ready=1, last=1 each cycle -> grants alternate 0,2,0,2; bin=0 then 2.
- req=8'hFF, cos[5]=3, others 0, last=1, ready=1 -> bin=5 every cycle; ages of the other 7 saturate at 15. From the 16th handshake onward, all aged requesters are top class and tie with requester 5, so round robin covers 6,7,0..5.
- Packet lock: req=8'b0000_0011, requester 0 wins; drive hs with last=0 for 3 beats, with cos[1] raised to 3 -> locked=1, bin=0 throughout. On the 4th beat with last=1, locked drops and the next grant is bin=1.
- Starvation: AGE_LIMIT=2, cos[3]=0, cos[1]=2, req bits 1 and 3 held, last=1 -> grants 1,1, then bin=3 on the third packet. age[3] clears afterwards, and the pattern repeats.
- In LOCK with lock_idx=4, drop req[4] for 2 cycles -> valid=0, bin=4, locked=1. Re-assert req[4] -> valid=1 with the same grant.
- Assert rst_n=0 mid-packet while locked=1 -> locked=0 and ages=0 immediately. With req=8'h01 after release -> bin=0, valid=1.

Source files
------------

// File: rtl/ldl_round_pkg.sv
// Shared definitions for the ldl_round family of arbiters.
// Holds the lock FSM state encoding and the default sizing constants.
// The per-instance vector, class and age types depend on module parameters,
// so each arbiter declares them locally from its own parameters.
package ldl_round_pkg;

  // ARB: grant computed fresh every cycle; LOCK: grant pinned to lock_idx.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int unsigned DEF_BIN_WIDTH = 3;
  localparam int unsigned DEF_COS_WIDTH = 2;
  localparam int unsigned DEF_AGE_WIDTH = 4;
  localparam int unsigned DEF_AGE_LIMIT = 15;

endpackage

// File: rtl/ldl_rr_pick.sv
// Combinational rotating-priority search.
// Scans cand starting at ptr+1 (mod REQ_WIDTH), wrapping, and reports the
// first set bit.
// Ports:
//   cand  candidate vector
//   ptr   index of the last winner; the search starts just after it
//   hot   one-hot of the winner (0 when no candidate)
//   bin   binary index of the winner (0 when no candidate)
//   any   at least one candidate present
module ldl_rr_pick #(
  parameter int BIN_WIDTH = 3,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic [REQ_WIDTH-1:0] cand,
  input  logic [BIN_WIDTH-1:0] ptr,
  output logic [REQ_WIDTH-1:0] hot,
  output logic [BIN_WIDTH-1:0] bin,
  output logic                 any
);

  // Walk offsets 1..REQ_WIDTH from ptr; index arithmetic wraps because
  // REQ_WIDTH is a power of two. The first candidate found is latched via any.
  always_comb begin
    logic [BIN_WIDTH-1:0] idx_s;
    logic                 take_s;
    hot    = '0;
    bin    = '0;
    any    = 1'b0;
    idx_s  = '0;
    take_s = 1'b0;
    for (int k = 1; k <= REQ_WIDTH; k++) begin
      idx_s  = ptr + BIN_WIDTH'(k);
      take_s = cand[idx_s] & ~any;
      hot    = hot | (take_s ? (REQ_WIDTH'(1) << idx_s) : '0);
      bin    = take_s ? idx_s : bin;
      any    = any | take_s;
    end
  end

endmodule

// File: rtl/ldl_round_pri_age.sv
// Class-of-service round-robin arbiter with anti-starvation aging and
// packet lock.
// A requester that keeps losing packets is promoted to top class once its age
// counter reaches AGE_LIMIT. A grant is held from the first non-last handshake
// until the last beat of that packet completes.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req         request vector
//   cos         packed per-requester class, requester i at [i*COS_WIDTH +: COS_WIDTH]
//   last        final beat of the current packet (used only on a handshake)
//   ready       downstream accepts the current beat
//   hot, bin    one-hot and binary grant
//   valid       grant is valid
//   locked      arbiter is holding a grant mid-packet
module ldl_round_pri_age
  import ldl_round_pkg::*;
#(
  parameter int BIN_WIDTH = DEF_BIN_WIDTH,
  parameter int COS_WIDTH = DEF_COS_WIDTH,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH,
  parameter int AGE_WIDTH = DEF_AGE_WIDTH,
  parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [REQ_WIDTH-1:0]           req,
  input  logic [REQ_WIDTH*COS_WIDTH-1:0] cos,
  input  logic                           last,
  input  logic                           ready,
  output logic [REQ_WIDTH-1:0]           hot,
  output logic [BIN_WIDTH-1:0]           bin,
  output logic                           valid,
  output logic                           locked
);

  typedef logic [REQ_WIDTH-1:0] req_vec_t;
  typedef logic [COS_WIDTH-1:0] cos_t;
  typedef logic [AGE_WIDTH-1:0] age_t;

  state_t               state_r, state_nxt_s;
  logic [BIN_WIDTH-1:0] ptr_r, ptr_nxt_s;
  logic [BIN_WIDTH-1:0] lock_idx_r, lock_idx_nxt_s;
  age_t                 age_r     [REQ_WIDTH];
  age_t                 age_nxt_s [REQ_WIDTH];
  cos_t                 eff_s     [REQ_WIDTH];
  cos_t                 max_eff_s;
  req_vec_t             cand_s;
  req_vec_t             pick_hot_s;
  logic [BIN_WIDTH-1:0] pick_bin_s;
  logic                 pick_any_s;
  logic                 hs_s;
  logic                 pe_s;

  // Effective class: a requester aged to the limit competes at all-ones.
  // max_eff only considers active requesters, so it is 0 with no requests.
  always_comb begin
    max_eff_s = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      eff_s[i]  = (age_r[i] >= AGE_WIDTH'(AGE_LIMIT)) ? '1 : cos[i*COS_WIDTH +: COS_WIDTH];
      max_eff_s = (req[i] && (eff_s[i] > max_eff_s)) ? eff_s[i] : max_eff_s;
    end
  end

  // Candidates are the active requesters sitting at the winning class.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      cand_s[i] = req[i] & (eff_s[i] == max_eff_s);
    end
  end

  ldl_rr_pick #(
    .BIN_WIDTH (BIN_WIDTH),
    .REQ_WIDTH (REQ_WIDTH)
  ) u_pick (
    .cand (cand_s),
    .ptr  (ptr_r),
    .hot  (pick_hot_s),
    .bin  (pick_bin_s),
    .any  (pick_any_s)
  );

  // Output mux: fresh pick in ARB, pinned lock_idx in LOCK. In LOCK the grant
  // stays visible even when the owner drops req; only valid follows req.
  always_comb begin
    hot   = pick_hot_s;
    bin   = pick_bin_s;
    valid = pick_any_s;
    case (state_r)
      ARB: begin
        hot   = pick_hot_s;
        bin   = pick_bin_s;
        valid = pick_any_s;
      end
      LOCK: begin
        hot   = REQ_WIDTH'(1) << lock_idx_r;
        bin   = lock_idx_r;
        valid = req[lock_idx_r];
      end
      default: begin
        hot   = pick_hot_s;
        bin   = pick_bin_s;
        valid = pick_any_s;
      end
    endcase
  end

  assign locked = (state_r == LOCK);
  assign hs_s   = valid & ready;
  assign pe_s   = hs_s & last;

  // Lock FSM next state: ptr moves only at packet end, to the winner.
  always_comb begin
    state_nxt_s    = state_r;
    ptr_nxt_s      = ptr_r;
    lock_idx_nxt_s = lock_idx_r;
    case (state_r)
      ARB: begin
        if (pe_s) begin
          ptr_nxt_s   = bin;
          state_nxt_s = ARB;
        end else if (hs_s) begin
          state_nxt_s    = LOCK;
          lock_idx_nxt_s = bin;
        end else begin
          state_nxt_s = ARB;
        end
      end
      LOCK: begin
        if (pe_s) begin
          state_nxt_s = ARB;
          ptr_nxt_s   = lock_idx_r;
        end else begin
          state_nxt_s = LOCK;
        end
      end
      default: begin
        state_nxt_s = ARB;
      end
    endcase
  end

  // Age update: idle requesters reset every cycle; on packet end the winner
  // resets and every other active requester counts one loss (saturating).
  always_comb begin
    for (int i = 0; i < REQ_WIDTH; i++) begin
      age_nxt_s[i] = age_r[i];
      if (!req[i]) begin
        age_nxt_s[i] = '0;
      end else if (pe_s && (bin == BIN_WIDTH'(i))) begin
        age_nxt_s[i] = '0;
      end else if (pe_s && (age_r[i] != '1)) begin
        age_nxt_s[i] = age_r[i] + AGE_WIDTH'(1);
      end else begin
        age_nxt_s[i] = age_r[i];
      end
    end
  end

  // FSM, round-robin pointer and lock index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB;
      ptr_r      <= BIN_WIDTH'(REQ_WIDTH - 1);
      lock_idx_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      lock_idx_r <= lock_idx_nxt_s;
    end
  end

  // Per-requester age counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        age_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        age_r[i] <= age_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_ldl_round_pri_age.sv
// Self-checking bench for ldl_round_pri_age. Two instances share stimulus:
// u_dut_a uses the default AGE_LIMIT=15, u_dut_b uses AGE_LIMIT=2.
// A behavioural model (ages, pointer, lock owner) predicts both.
module tb_ldl_round_pri_age;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [15:0] cos;
  logic        last;
  logic        ready;
  logic [7:0]  hot_a, hot_b;
  logic [2:0]  bin_a, bin_b;
  logic        valid_a, valid_b, locked_a, locked_b;

  int total = 0;
  int bad   = 0;

  ldl_round_pri_age u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .cos(cos), .last(last), .ready(ready),
    .hot(hot_a), .bin(bin_a), .valid(valid_a), .locked(locked_a)
  );

  ldl_round_pri_age #(.AGE_LIMIT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .cos(cos), .last(last), .ready(ready),
    .hot(hot_b), .bin(bin_b), .valid(valid_b), .locked(locked_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int limit [2] = '{15, 2};
  int m_ptr [2];
  bit m_lk  [2];
  int m_li  [2];
  int m_age [2][8];

  function automatic int eff(input int n, input int i);
    logic [15:0] c;
    c = cos;
    return (m_age[n][i] >= limit[n]) ? 3 : int'(c[i*2 +: 2]);
  endfunction

  // Expected {locked, valid, bin[2:0], hot[7:0]} for model instance n.
  function automatic logic [12:0] mexp(input int n);
    logic [7:0] h;
    int b, mx;
    logic v;
    h = 8'h00; b = 0; v = 1'b0; mx = 0;
    if (m_lk[n]) begin
      b = m_li[n];
      h = 8'h01 << b;
      v = req[b];
    end else begin
      for (int i = 0; i < 8; i++)
        if (req[i] && eff(n, i) > mx) mx = eff(n, i);
      for (int k = 1; k <= 8; k++) begin
        int idx;
        idx = (m_ptr[n] + k) % 8;
        if (!v && req[idx] && eff(n, idx) == mx) begin
          v = 1'b1; b = idx; h = 8'h01 << idx;
        end
      end
    end
    return {m_lk[n], v, b[2:0], h};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        m_ptr[n] <= 7;
        m_lk[n]  <= 1'b0;
        m_li[n]  <= 0;
        for (int i = 0; i < 8; i++) m_age[n][i] <= 0;
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        automatic logic [12:0] e = mexp(n);
        automatic int  b  = int'(e[10:8]);
        automatic bit  hs = e[11] & ready;
        automatic bit  pe = hs & last;
        if (pe) begin
          m_ptr[n] <= b;
          m_lk[n]  <= 1'b0;
        end else if (hs) begin
          m_lk[n] <= 1'b1;
          m_li[n] <= b;
        end
        for (int i = 0; i < 8; i++) begin
          if (!req[i]) m_age[n][i] <= 0;
          else if (pe && i == b) m_age[n][i] <= 0;
          else if (pe) m_age[n][i] <= (m_age[n][i] >= 15) ? 15 : m_age[n][i] + 1;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0; req = 8'h00; cos = 16'h0000; last = 1'b0; ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; req = 8'h00; cos = 16'h0000; last = 1'b0; ready = 1'b1;
    #2;
    total++;
    if ({locked_a, valid_a, bin_a, hot_a} !== 13'h0000) begin
      bad++;
      $display("FAIL reset_out got=%h want=%h", {locked_a, valid_a, bin_a, hot_a}, 13'h0000);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_alternate;
    apply_reset();
    req = 8'b0000_0101; ready = 1'b1; last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      automatic logic [2:0] eb = (k % 2 == 1) ? 3'd2 : 3'd0;
      #2;
      total++;
      if (bin_a !== eb || valid_a !== 1'b1 || hot_a !== (8'h01 << eb)) begin
        bad++;
        $display("FAIL alternate[%0d] got bin=%0d v=%b hot=%h want bin=%0d", k, bin_a, valid_a, hot_a, eb);
      end
      tick();
    end
  endtask

  task automatic test_cos_age;
    automatic int seq [8] = '{6, 7, 0, 1, 2, 3, 4, 5};
    apply_reset();
    req = 8'hFF; cos = 16'h0C00; ready = 1'b1; last = 1'b1;
    for (int p = 0; p < 23; p++) begin
      automatic int eb = (p < 15) ? 5 : seq[p-15];
      #2;
      total++;
      if (int'(bin_a) != eb || valid_a !== 1'b1) begin
        bad++;
        $display("FAIL cos_age[%0d] got bin=%0d v=%b want bin=%0d", p, bin_a, valid_a, eb);
      end
      tick();
    end
  endtask

  task automatic test_lock;
    apply_reset();
    req = 8'b0000_0011; ready = 1'b1; last = 1'b0;
    #2;
    total++;
    if (bin_a !== 3'd0 || locked_a !== 1'b0) begin
      bad++;
      $display("FAIL lock_first got bin=%0d lk=%b want bin=0 lk=0", bin_a, locked_a);
    end
    tick();
    cos = 16'h000C;
    for (int b = 0; b < 3; b++) begin
      last = (b == 2);
      #2;
      total++;
      if (bin_a !== 3'd0 || locked_a !== 1'b1 || valid_a !== 1'b1) begin
        bad++;
        $display("FAIL lock_hold[%0d] got bin=%0d lk=%b v=%b want bin=0 lk=1 v=1", b, bin_a, locked_a, valid_a);
      end
      tick();
    end
    #2;
    total++;
    if (bin_a !== 3'd1 || locked_a !== 1'b0) begin
      bad++;
      $display("FAIL lock_release got bin=%0d lk=%b want bin=1 lk=0", bin_a, locked_a);
    end
    tick();
  endtask

  task automatic test_starve;
    apply_reset();
    req = 8'b0000_1010; cos = 16'h0008; ready = 1'b1; last = 1'b1;
    for (int p = 0; p < 6; p++) begin
      automatic logic [2:0] eb = (p % 3 == 2) ? 3'd3 : 3'd1;
      #2;
      total++;
      if (bin_b !== eb || valid_b !== 1'b1) begin
        bad++;
        $display("FAIL starve_b[%0d] got bin=%0d want bin=%0d", p, bin_b, eb);
      end
      total++;
      if (bin_a !== 3'd1) begin
        bad++;
        $display("FAIL starve_a[%0d] got bin=%0d want bin=1", p, bin_a);
      end
      tick();
    end
  endtask

  task automatic test_drop;
    apply_reset();
    req = 8'h10; ready = 1'b1; last = 1'b0;
    tick();
    req = 8'h00;
    for (int c = 0; c < 2; c++) begin
      #2;
      total++;
      if (valid_a !== 1'b0 || bin_a !== 3'd4 || hot_a !== 8'h10 || locked_a !== 1'b1) begin
        bad++;
        $display("FAIL drop[%0d] got v=%b bin=%0d hot=%h lk=%b want v=0 bin=4 hot=10 lk=1",
                 c, valid_a, bin_a, hot_a, locked_a);
      end
      tick();
    end
    req = 8'h10;
    #2;
    total++;
    if (valid_a !== 1'b1 || bin_a !== 3'd4 || locked_a !== 1'b1) begin
      bad++;
      $display("FAIL drop_reassert got v=%b bin=%0d lk=%b want v=1 bin=4 lk=1", valid_a, bin_a, locked_a);
    end
    tick();
  endtask

  task automatic test_async_reset;
    apply_reset();
    // Give requester 3 one loss on the AGE_LIMIT=2 instance, then lock on 1.
    req = 8'b0000_1010; cos = 16'h0008; ready = 1'b1; last = 1'b1;
    tick();
    last = 1'b0;
    tick();
    #2;
    total++;
    if (locked_b !== 1'b1 || locked_a !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre got lk_a=%b lk_b=%b want 1 1", locked_a, locked_b);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (locked_a !== 1'b0 || locked_b !== 1'b0) begin
      bad++;
      $display("FAIL areset_now got lk_a=%b lk_b=%b want 0 0", locked_a, locked_b);
    end
    tick();
    rst_n = 1'b1; last = 1'b1;
    // Cleared ages mean requester 3 needs two fresh losses before promotion.
    for (int p = 0; p < 3; p++) begin
      automatic logic [2:0] eb = (p == 2) ? 3'd3 : 3'd1;
      #2;
      total++;
      if (bin_b !== eb) begin
        bad++;
        $display("FAIL areset_age[%0d] got bin=%0d want bin=%0d", p, bin_b, eb);
      end
      tick();
    end
    req = 8'h01;
    #2;
    total++;
    if (bin_a !== 3'd0 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL areset_req01 got bin=%0d v=%b want bin=0 v=1", bin_a, valid_a);
    end
    tick();
  endtask

  task automatic test_random;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) != 0) req = 8'($urandom | $urandom);
      if ($urandom_range(0, 7) == 0) cos = 16'($urandom);
      last  = ($urandom_range(0, 3) != 0);
      ready = ($urandom_range(0, 4) != 0);
      #2;
      total++;
      if ({locked_a, valid_a, bin_a, hot_a} !== mexp(0)) begin
        bad++;
        $display("FAIL random_a[%0d] got=%h want=%h", c, {locked_a, valid_a, bin_a, hot_a}, mexp(0));
      end
      total++;
      if ({locked_b, valid_b, bin_b, hot_b} !== mexp(1)) begin
        bad++;
        $display("FAIL random_b[%0d] got=%h want=%h", c, {locked_b, valid_b, bin_b, hot_b}, mexp(1));
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = 8'h00; cos = 16'h0000; last = 1'b0; ready = 1'b0;
    #1;
    test_reset();
    test_alternate();
    test_cos_age();
    test_lock();
    test_starve();
    test_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
